// File: rtl/m_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing IF/ID/EX/MEM/WB and driving
// every datapath select and write strobe; memory not-ready stalls the sequence.
module m_ctrl #(
    parameter int ST_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     Inst_in,
    input  logic            zero,
    input  logic            MIO_ready,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [2:0]      ALU_operation,
    output logic            Branch,
    output logic            IorD,
    output logic            IRWrite,
    output logic [1:0]      MemtoReg,
    output logic [1:0]      PCSource,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic [1:0]      RegDst,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            CPU_MIO,
    output logic            illegal,
    output logic [ST_W-1:0] state
);

    typedef enum logic [ST_W-1:0] {
        S_IF  = ST_W'(0),
        S_ID  = ST_W'(1),
        S_MA  = ST_W'(2),
        S_MR  = ST_W'(3),
        S_WBL = ST_W'(4),
        S_MW  = ST_W'(5),
        S_EXR = ST_W'(6),
        S_WBR = ST_W'(7),
        S_BEQ = ST_W'(8),
        S_JMP = ST_W'(9),
        S_EXI = ST_W'(10),
        S_WBI = ST_W'(11),
        S_JAL = ST_W'(12),
        S_ILL = ST_W'(13)
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    state_t     state_q, state_d;
    logic [5:0] opcode, funct;
    logic       ir_wr, pc_wr, pc_wc, reg_wr, mem_rd, mem_wr;
    logic       strobe_en;
    logic       unused_ok;

    assign opcode    = Inst_in[31:26];
    assign funct     = Inst_in[5:0];
    assign unused_ok = ^{zero, Inst_in[25:6]};

    function automatic logic r_supported(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010, 6'b000010: r_supported = 1'b1;
            default:                                    r_supported = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            6'b100111: r_alu = ALU_NOR;
            6'b101010: r_alu = ALU_SLT;
            6'b000010: r_alu = ALU_SRL;
            default:   r_alu = ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            OP_SLTI: i_alu = ALU_SLT;
            default: i_alu = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        state_d       = S_IF;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'd0;
        ALU_operation = ALU_AND;
        Branch        = 1'b0;
        IorD          = 1'b0;
        MemtoReg      = 2'd0;
        PCSource      = 2'd0;
        RegDst        = 2'd0;
        illegal       = 1'b0;
        ir_wr         = 1'b0;
        pc_wr         = 1'b0;
        pc_wc         = 1'b0;
        reg_wr        = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        case (state_q)
            S_IF: begin
                mem_rd        = 1'b1;
                ir_wr         = 1'b1;
                ALUSrcB       = 2'd1;
                ALU_operation = ALU_ADD;
                pc_wr         = 1'b1;
                state_d       = S_ID;
            end
            S_ID: begin
                ALUSrcB       = 2'd3;
                ALU_operation = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                          state_d = r_supported(funct) ? S_EXR : S_ILL;
                    OP_LW, OP_SW:                      state_d = S_MA;
                    OP_BEQ:                            state_d = S_BEQ;
                    OP_J:                              state_d = S_JMP;
                    OP_JAL:                            state_d = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXI;
                    default:                           state_d = S_ILL;
                endcase
            end
            S_MA: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'd2;
                ALU_operation = ALU_ADD;
                state_d       = (opcode == OP_LW) ? S_MR : S_MW;
            end
            S_MR: begin
                mem_rd  = 1'b1;
                IorD    = 1'b1;
                state_d = S_WBL;
            end
            S_WBL: begin
                MemtoReg = 2'd1;
                reg_wr   = 1'b1;
            end
            S_MW: begin
                mem_wr = 1'b1;
                IorD   = 1'b1;
            end
            S_EXR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = r_alu(funct);
                state_d       = S_WBR;
            end
            S_WBR: begin
                RegDst = 2'd1;
                reg_wr = 1'b1;
            end
            // Branch compares rs and rt by subtraction; the datapath qualifies the PC write with zero
            S_BEQ: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_SUB;
                pc_wc         = 1'b1;
                Branch        = 1'b1;
                PCSource      = 2'd1;
            end
            S_JMP: begin
                PCSource = 2'd2;
                pc_wr    = 1'b1;
            end
            S_EXI: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'd2;
                ALU_operation = i_alu(opcode);
                state_d       = S_WBI;
            end
            S_WBI: begin
                reg_wr = 1'b1;
            end
            S_JAL: begin
                RegDst   = 2'd2;
                MemtoReg = 2'd2;
                reg_wr   = 1'b1;
                PCSource = 2'd2;
                pc_wr    = 1'b1;
            end
            S_ILL: begin
                illegal = 1'b1;
            end
            default: state_d = S_IF;
        endcase
        if (!MIO_ready) begin
            state_d = state_q;
        end
    end

    // Strobes are masked combinationally so a stall or reset never lets a write through
    assign strobe_en   = MIO_ready & ~reset;
    assign IRWrite     = ir_wr  & strobe_en;
    assign PCWrite     = pc_wr  & strobe_en;
    assign PCWriteCond = pc_wc  & strobe_en;
    assign RegWrite    = reg_wr & strobe_en;
    assign MemRead     = mem_rd & strobe_en;
    assign MemWrite    = mem_wr & strobe_en;
    assign CPU_MIO     = MemRead | MemWrite;
    assign state       = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_m_ctrl.sv
// Bench for m_ctrl: directed vector table, a reset-mid-instruction sequence, then
// randomized instructions/stalls/resets against an instruction-level reference model.
module tb_m_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Inst_in;
    logic        zero;
    logic        MIO_ready;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALU_operation;
    logic        Branch, IorD, IRWrite;
    logic [1:0]  MemtoReg, PCSource;
    logic        PCWrite, PCWriteCond;
    logic [1:0]  RegDst;
    logic        RegWrite, MemRead, MemWrite, CPU_MIO, illegal;
    logic [4:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_ctrl #(.ST_W(5)) dut (
        .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .MIO_ready(MIO_ready),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_operation(ALU_operation), .Branch(Branch),
        .IorD(IorD), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .illegal(illegal),
        .state(state)
    );

    typedef struct packed {
        logic       asa;
        logic [1:0] asb;
        logic [2:0] alu;
        logic       br;
        logic       iord;
        logic       irw;
        logic [1:0] m2r;
        logic [1:0] pcs;
        logic       pcw;
        logic       pcwc;
        logic [1:0] rdst;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       mio;
        logic       ill;
    } outs_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] inst;
        logic [4:0]  st;
        logic [2:0]  alu;
        logic [5:0]  strb;
        logic [5:0]  sel;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic rst, input logic rdy, input logic [31:0] inst, input int st,
                        input logic [2:0] alu, input logic [5:0] strb, input logic [5:0] sel,
                        input logic ill);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.inst = inst; v.st = 5'(st);
        v.alu = alu; v.strb = strb; v.sel = sel; v.ill = ill;
        vecs.push_back(v);
    endtask

    // {valid, alu op} for an R-type funct
    function automatic logic [3:0] r_info(input logic [5:0] f);
        case (f)
            6'h20: r_info = 4'b1_010;
            6'h22: r_info = 4'b1_110;
            6'h24: r_info = 4'b1_000;
            6'h25: r_info = 4'b1_001;
            6'h26: r_info = 4'b1_011;
            6'h27: r_info = 4'b1_100;
            6'h2A: r_info = 4'b1_111;
            6'h02: r_info = 4'b1_101;
            default: r_info = 4'b0_010;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            6'h0C:   i_alu = 3'b000;
            6'h0D:   i_alu = 3'b001;
            6'h0A:   i_alu = 3'b111;
            default: i_alu = 3'b010;
        endcase
    endfunction

    // States visited after ID, one nibble each, lowest first; an empty nibble means back to IF
    function automatic logic [15:0] path_of(input logic [31:0] inst);
        case (inst[31:26])
            6'h00:                      path_of = r_info(inst[5:0])[3] ? 16'h0076 : 16'h000D;
            6'h23:                      path_of = 16'h0432;
            6'h2B:                      path_of = 16'h0052;
            6'h04:                      path_of = 16'h0008;
            6'h02:                      path_of = 16'h0009;
            6'h03:                      path_of = 16'h000C;
            6'h08, 6'h0C, 6'h0D, 6'h0A: path_of = 16'h00BA;
            default:                    path_of = 16'h000D;
        endcase
    endfunction

    function automatic outs_t spec_outs(input int st, input logic [31:0] inst,
                                        input logic rst, input logic rdy);
        outs_t o = '0;
        case (st)
            0:  begin o.mr = 1; o.irw = 1; o.asb = 1; o.alu = 3'b010; o.pcw = 1; end
            1:  begin o.asb = 3; o.alu = 3'b010; end
            2:  begin o.asa = 1; o.asb = 2; o.alu = 3'b010; end
            3:  begin o.mr = 1; o.iord = 1; end
            4:  begin o.m2r = 1; o.rw = 1; end
            5:  begin o.mw = 1; o.iord = 1; end
            6:  begin o.asa = 1; o.alu = r_info(inst[5:0])[2:0]; end
            7:  begin o.rdst = 1; o.rw = 1; end
            8:  begin o.asa = 1; o.alu = 3'b110; o.pcwc = 1; o.br = 1; o.pcs = 1; end
            9:  begin o.pcs = 2; o.pcw = 1; end
            10: begin o.asa = 1; o.asb = 2; o.alu = i_alu(inst[31:26]); end
            11: begin o.rw = 1; end
            12: begin o.rdst = 2; o.m2r = 2; o.rw = 1; o.pcs = 2; o.pcw = 1; end
            13: begin o.ill = 1; end
            default: ;
        endcase
        if (rst || !rdy) begin
            o.irw = 0; o.pcw = 0; o.pcwc = 0; o.rw = 0; o.mr = 0; o.mw = 0;
        end
        o.mio = o.mr | o.mw;
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.asa = ALUSrcA; o.asb = ALUSrcB; o.alu = ALU_operation; o.br = Branch;
        o.iord = IorD; o.irw = IRWrite; o.m2r = MemtoReg; o.pcs = PCSource;
        o.pcw = PCWrite; o.pcwc = PCWriteCond; o.rdst = RegDst; o.rw = RegWrite;
        o.mr = MemRead; o.mw = MemWrite; o.mio = CPU_MIO; o.ill = illegal;
        return o;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom();
        case ($urandom_range(0, 9))
            0: r[31:26] = 6'h23;
            1: r[31:26] = 6'h2B;
            2: begin
                r[31:26] = 6'h00;
                case ($urandom_range(0, 7))
                    0: r[5:0] = 6'h20; 1: r[5:0] = 6'h22; 2: r[5:0] = 6'h24; 3: r[5:0] = 6'h25;
                    4: r[5:0] = 6'h26; 5: r[5:0] = 6'h27; 6: r[5:0] = 6'h2A; default: r[5:0] = 6'h02;
                endcase
            end
            3: r[31:26] = 6'h00;
            4: r[31:26] = 6'h04;
            5: r[31:26] = 6'h02;
            6: r[31:26] = 6'h03;
            7: case ($urandom_range(0, 3))
                   0: r[31:26] = 6'h08; 1: r[31:26] = 6'h0C; 2: r[31:26] = 6'h0D; default: r[31:26] = 6'h0A;
               endcase
            default: ;
        endcase
        return r;
    endfunction

    localparam logic [31:0] LW  = 32'h8C010004;
    localparam logic [31:0] ADD = 32'h00221820;
    localparam logic [31:0] SUB = 32'h00221822;
    localparam logic [31:0] BEQ = 32'h10220003;
    localparam logic [31:0] JAL = 32'h0C000010;
    localparam logic [31:0] BAD = 32'hFC000000;
    localparam logic [31:0] BFN = 32'h0000003F;

    initial begin
        int         mst;
        logic [15:0] rest;
        outs_t      exp_o;

        // rst rdy inst st alu {irw,pcw,pcwc,rw,mr,mw} {rdst,m2r,pcs} ill
        addv(1, 1, LW,  0,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, LW,  0,  3'b010, 6'b110010, 6'b000000, 0);
        addv(0, 1, LW,  1,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, LW,  2,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, LW,  3,  3'b000, 6'b000010, 6'b000000, 0);
        addv(0, 1, LW,  4,  3'b000, 6'b000100, 6'b000100, 0);
        addv(0, 1, ADD, 0,  3'b010, 6'b110010, 6'b000000, 0);
        addv(0, 1, ADD, 1,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, ADD, 6,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, ADD, 7,  3'b000, 6'b000100, 6'b010000, 0);
        addv(0, 1, SUB, 0,  3'b010, 6'b110010, 6'b000000, 0);
        addv(0, 1, SUB, 1,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, SUB, 6,  3'b110, 6'b000000, 6'b000000, 0);
        addv(0, 1, SUB, 7,  3'b000, 6'b000100, 6'b010000, 0);
        addv(0, 1, BEQ, 0,  3'b010, 6'b110010, 6'b000000, 0);
        addv(0, 1, BEQ, 1,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, BEQ, 8,  3'b110, 6'b001000, 6'b000001, 0);
        addv(0, 1, LW,  0,  3'b010, 6'b110010, 6'b000000, 0);
        addv(0, 1, LW,  1,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, LW,  2,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 0, LW,  3,  3'b000, 6'b000000, 6'b000000, 0);
        addv(0, 0, LW,  3,  3'b000, 6'b000000, 6'b000000, 0);
        addv(0, 0, LW,  3,  3'b000, 6'b000000, 6'b000000, 0);
        addv(0, 1, LW,  3,  3'b000, 6'b000010, 6'b000000, 0);
        addv(0, 1, LW,  4,  3'b000, 6'b000100, 6'b000100, 0);
        addv(0, 1, JAL, 0,  3'b010, 6'b110010, 6'b000000, 0);
        addv(0, 1, JAL, 1,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, JAL, 12, 3'b000, 6'b010100, 6'b101010, 0);
        addv(0, 1, BAD, 0,  3'b010, 6'b110010, 6'b000000, 0);
        addv(0, 1, BAD, 1,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, BAD, 13, 3'b000, 6'b000000, 6'b000000, 1);
        addv(0, 0, BFN, 0,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 0, BFN, 0,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, BFN, 0,  3'b010, 6'b110010, 6'b000000, 0);
        addv(0, 1, BFN, 1,  3'b010, 6'b000000, 6'b000000, 0);
        addv(0, 1, BFN, 13, 3'b000, 6'b000000, 6'b000000, 1);
        addv(0, 1, BFN, 0,  3'b010, 6'b110010, 6'b000000, 0);

        reset = 1'b1; MIO_ready = 1'b1; Inst_in = '0; zero = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; MIO_ready = vecs[i].rdy; Inst_in = vecs[i].inst;
            zero = 1'($urandom());
            #1;
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].st));
            chk($sformatf("vec%0d_outs", i),
                64'({ALU_operation, IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite,
                     RegDst, MemtoReg, PCSource, illegal}),
                64'({vecs[i].alu, vecs[i].strb, vecs[i].sel, vecs[i].ill}));
            @(posedge clk); #1;
        end

        // Reset asserted mid-EXR: state and strobes must drop before any clock edge
        Inst_in = ADD; MIO_ready = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_exr", 64'(state), 64'd6);
        #2 reset = 1'b1;
        #1;
        chk("reset_async_state", 64'(state), 64'd0);
        chk("reset_strobes", 64'({IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite, CPU_MIO}), 64'd0);
        chk("reset_selects", 64'({ALUSrcA, ALUSrcB, ALU_operation, IorD, PCSource}), 64'({1'b0, 2'd1, 3'b010, 1'b0, 2'd0}));
        reset = 1'b0;
        #1;
        chk("release_if_strobes", 64'({MemRead, IRWrite, PCWrite, CPU_MIO}), 64'hF);
        @(posedge clk); #1;
        chk("release_to_id", 64'(state), 64'd1);

        // Randomized run against the instruction-level model
        mst = 0; rest = '0;
        for (int c = 0; c < 2000; c++) begin
            reset     = (c == 0) || ($urandom_range(0, 59) == 0);
            MIO_ready = ($urandom_range(0, 3) != 0);
            zero      = 1'($urandom());
            if (reset) begin
                mst = 0; rest = '0;
            end
            if (mst == 0) Inst_in = rand_inst();
            #1;
            exp_o = spec_outs(mst, Inst_in, reset, MIO_ready);
            chk($sformatf("rnd%0d_state", c), 64'(state), 64'(mst));
            chk($sformatf("rnd%0d_outs_st%0d", c, mst), 64'(dut_outs()), 64'(exp_o));
            @(posedge clk); #1;
            if (!reset && MIO_ready) begin
                if (mst == 0) begin
                    mst = 1;
                end else begin
                    if (mst == 1) rest = path_of(Inst_in);
                    mst  = int'(rest[3:0]);
                    rest = rest >> 4;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_ctrl.md
Name: m_ctrl

Overview:
- Multicycle MIPS control unit; sits directly upstream of the multicycle datapath and drives all of its mux selects and write strobes.
- Moore FSM: decodes the opcode/funct of the instruction register output and sequences IF/ID/EX/MEM/WB cycles.
- Stalls on memory/IO not-ready.
- Also drives the memory-side read/write strobes and a state/illegal-opcode status for debug.

Parameters:
- ST_W, 5, width of state register / state output

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-high reset
- Inst_in  input  32  current instruction register contents; only [31:26] and [5:0] decoded
- zero  input  1  ALU zero flag (status only; branch resolution gated in datapath)
- MIO_ready  input  1  memory/IO ready; 0 = stall
- ALUSrcA  output  1  0=PC, 1=rs
- ALUSrcB  output  2  0=rt, 1=const 4, 2=imm32, 3=imm32<<2
- ALU_operation  output  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt
- Branch  output  1  branch-on-zero qualifier
- IorD  output  1  memory address: 0=PC, 1=ALUOut
- IRWrite  output  1  instruction register load
- MemtoReg  output  2  0=ALUOut, 1=MDR, 2=PC
- PCSource  output  2  0=ALU result, 1=ALUOut, 2=jump address
- PCWrite  output  1  unconditional PC write
- PCWriteCond  output  1  conditional PC write
- RegDst  output  2  0=rt, 1=rd, 2=$31
- RegWrite  output  1  register file write
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- CPU_MIO  output  1  bus request; equals MemRead|MemWrite
- illegal  output  1  high for the ILL state cycle
- state  output  ST_W  current state code

Behaviour:
- Clocking and reset:
  - The state register is the only flop.
  - reset=1 asynchronously forces state=IF (0).
  - While reset is high, all write strobes (IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite, CPU_MIO) are 0.
  - Selects take IF values.
- Outputs:
  - All outputs decode from state alone; Inst_in only affects the next state and ALU_operation.
  - Signals not listed for a state are 0.
- Stall:
  - If MIO_ready=0, the state holds.
  - All write/memory strobes are forced 0 that cycle; selects keep their state values.
  - The state advances only on a clock edge with MIO_ready=1.
- States, signals and transitions:
  - IF=0: MemRead, IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=1, add, PCSource=0, PCWrite -> ID.
  - ID=1: ALUSrcA=0, ALUSrcB=3, add (branch target to ALUOut). Next state by opcode Inst_in[31:26]:
    - 000000 -> EXR if funct is supported, else ILL
    - 100011/101011 -> MA
    - 000100 -> BEQ
    - 000010 -> JMP
    - 000011 -> JAL
    - 001000/001100/001101/001010 -> EXI
    - any other -> ILL
  - MA=2: ALUSrcA=1, ALUSrcB=2, add -> MR for lw, MW for sw.
  - MR=3: MemRead, IorD=1 -> WBL.
  - WBL=4: RegDst=0, MemtoReg=1, RegWrite -> IF.
  - MW=5: MemWrite, IorD=1 -> IF.
  - EXR=6: ALUSrcA=1, ALUSrcB=0. ALU_operation by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl. -> WBR.
  - WBR=7: RegDst=1, MemtoReg=0, RegWrite -> IF.
  - BEQ=8: ALUSrcA=1, ALUSrcB=0, sub, PCWriteCond, Branch, PCSource=1 -> IF.
  - JMP=9: PCSource=2, PCWrite -> IF.
  - EXI=10: ALUSrcA=1, ALUSrcB=2. ALU_operation: addi add, andi and, ori or, slti slt. -> WBI.
  - WBI=11: RegDst=0, MemtoReg=0, RegWrite -> IF.
  - JAL=12: RegDst=2, MemtoReg=2, RegWrite, PCSource=2, PCWrite -> IF.
  - ILL=13: illegal=1, no strobes -> IF (instruction skipped; PC already advanced).
  - Unused codes 14..31: outputs idle, next state IF.
- Latency (unstalled cycles, IF to next IF): lw 5, sw 4, R-type 4, I-type 4, beq 3, j 3, jal 3, illegal 3.
- Boundaries:
  - Reset mid-instruction abandons it; no strobe glitches on the reset edge.
  - A stall in MR/MW/IF holds the strobe state while strobes stay low.
  - The first MIO_ready=1 cycle performs the access.
  - Overflow is not handled (no exception state).

Test Plan:
- Reset: assert reset mid-EXR -> state=0 immediately; all strobes 0. Release -> IF strobes: MemRead=1, IRWrite=1, PCWrite=1.
- lw (Inst_in=8C010004), MIO_ready=1 -> states 0,1,2,3,4,0. WBL has RegWrite=1, MemtoReg=1, RegDst=0.
- add (00221820) then sub (00221822) -> EXR ALU_operation=010 then 110; WBR RegDst=1.
- beq (10220003) -> state 8 with PCWriteCond=1, Branch=1, PCSource=1, ALU_operation=110; next state 0.
- Stall: MIO_ready=0 for 3 cycles in MR -> state stays 3, MemRead=0. MIO_ready=1 -> MemRead=1, then state 4.
- jal (0C000010) -> state 12: RegDst=2, MemtoReg=2, PCSource=2, RegWrite=1, PCWrite=1. Opcode 111111 -> ILL with illegal=1 for one cycle, then IF.
